// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
//   Adds or subtracts two WORDS*16-bit operands with one shared 16-bit
//   carry-select adder. The adder handles one word per clock, least
//   significant word first. A carry register links one word to the next.
//   A valid/ready handshake accepts the operands, and a second valid/ready
//   handshake returns the result.
//
// Ports
//   Clk        in   1          rising-edge clock
//   Rst_n      in   1          asynchronous active-low reset
//   In_valid   in   1          operands and op are valid this cycle
//   In_ready   out  1          high in IDLE only; new operation can be taken
//   Op         in   1          0 = X+Y+Cin, 1 = X-Y (Cin ignored)
//   Cin        in   1          carry-in for add
//   X, Y       in   WORDS*16   operands
//   Out_valid  out  1          result valid; held until Out_ready
//   Out_ready  in   1          consumer accepts the result
//   S          out  WORDS*16   result
//   Cout       out  1          add: carry out; sub: 1 = no borrow (X >= Y)
//   Ovf        out  1          signed overflow of the full-width result
// -----------------------------------------------------------------------------

// 16-bit carry-select adder. The upper byte is computed for both possible
// carry-ins, and the carry out of the low byte picks one of the two results.
module carry_select_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [8:0] lo_s;
    logic [8:0] hi0_s;
    logic [8:0] hi1_s;

    assign lo_s  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
    assign hi0_s = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign hi1_s = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

    assign s    = {(lo_s[8] ? hi1_s[7:0] : hi0_s[7:0]), lo_s[7:0]};
    assign cout = lo_s[8] ? hi1_s[8] : hi0_s[8];
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic                  Op,
    input  logic                  Cin,
    input  logic [WORDS*16-1:0]   X,
    input  logic [WORDS*16-1:0]   Y,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [WORDS*16-1:0]   S,
    output logic                  Cout,
    output logic                  Ovf
);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WORDS-1:0][15:0]  x_q, x_d;
    logic [WORDS-1:0][15:0]  y_q, y_d;      // holds Y, or ~Y for subtract
    logic [WORDS-1:0][15:0]  s_q, s_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic [15:0]             add_s;
    logic                    add_cout;

    // The only arithmetic resource. Each cycle it takes the word that idx selects.
    carry_select_adder u_add (
        .a    (x_q[idx_q]),
        .b    (y_q[idx_q]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (In_valid && in_ready_q) begin
                    x_d        = X;
                    // Subtract is X + ~Y + 1, so the adder only ever adds.
                    y_d        = Op ? ~Y : Y;
                    carry_d    = Op ? 1'b1 : Cin;
                    idx_d      = {IDX_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                s_d[idx_q] = add_s;
                carry_d    = add_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d      = add_cout;
                    // Operand signs are equal but the result sign differs.
                    ovf_d       = (x_q[WORDS-1][15] == y_q[WORDS-1][15]) &&
                                  (add_s[15] != x_q[WORDS-1][15]);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (Out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears them immediately, and any
    // partial result is lost.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= '0;
            idx_q       <= {IDX_W{1'b0}};
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Testbench for multiword_add_seq with WORDS=4 (64-bit operands).
module tb_multiword_add_seq;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic        cin;
    logic [63:0] x;
    logic [63:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;
    logic        cout;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Op        (op),
        .Cin       (cin),
        .X         (x),
        .Y         (y),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .S         (s),
        .Cout      (cout),
        .Ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic        op;
        logic        cin;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: full-width arithmetic on whole operands.
    task automatic model(input logic [63:0] xv, input logic [63:0] yv, input logic opv,
                         input logic cinv, output logic [63:0] rs, output logic rc,
                         output logic ro);
        logic [64:0] t;
        if (!opv) begin
            t  = {1'b0, xv} + {1'b0, yv} + {64'd0, cinv};
            rs = t[63:0];
            rc = t[64];
            ro = (xv[63] == yv[63]) && (rs[63] != xv[63]);
        end else begin
            rs = xv - yv;
            rc = (xv >= yv);
            ro = (xv[63] != yv[63]) && (rs[63] != xv[63]);
        end
    endtask

    // Run one operation. Hold the result for 'stall' cycles. If junk is set,
    // keep In_valid high with random operands while the operation is busy.
    task automatic do_op(input logic [63:0] xv, input logic [63:0] yv, input logic opv,
                         input logic cinv, input int stall, input bit junk,
                         output logic [63:0] rs, output logic rc, output logic ro,
                         output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 80'(in_ready), 80'(1'b1));
        x = xv; y = yv; op = opv; cin = cinv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = junk;
        if (junk) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom}; op = 1'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (junk) begin
                x = {$urandom, $urandom}; y = {$urandom, $urandom}; cin = 1'($urandom);
            end
        end
        if (!out_valid) chk("out_valid_timeout", 80'(out_valid), 80'(1'b1));
        rs = s; rc = cout; ro = ovf;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold", 80'({out_valid, in_ready, cout, ovf, s}), 80'({1'b1, 1'b0, rc, ro, rs}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release", 80'({out_valid, in_ready}), 80'(2'b01));
    endtask

    initial begin
        logic [63:0] rs, es;
        logic        rc, ro, ec, eo;
        int          lat;
        logic [63:0] rx, ry;
        logic        rop, rcin;

        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; cin = 1'b0;
        x = 64'd0; y = 64'd0; out_ready = 1'b0;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
        tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[2] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0};
        tbl[4] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 80'({in_ready, out_valid, cout, ovf, s}), 80'({1'b1, 1'b0, 1'b0, 1'b0, 64'd0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].cin, 0, 1'b0, rs, rc, ro, lat);
            chk("tbl_s", 80'(rs), 80'(tbl[i].s));
            chk("tbl_cout", 80'(rc), 80'(tbl[i].cout));
            chk("tbl_ovf", 80'(ro), 80'(tbl[i].ovf));
            chk("tbl_latency", 80'(lat), 80'(WORDS));
        end

        // Long stall with In_valid noise during RUN and DONE
        model(64'h1111_2222_3333_4444, 64'h0FFF_EEEE_DDDD_CCCC, 1'b0, 1'b1, es, ec, eo);
        do_op(64'h1111_2222_3333_4444, 64'h0FFF_EEEE_DDDD_CCCC, 1'b0, 1'b1, 10, 1'b1, rs, rc, ro, lat);
        chk("stall_result", 80'({rc, ro, rs}), 80'({ec, eo, es}));
        model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, es, ec, eo);
        do_op(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 0, 1'b0, rs, rc, ro, lat);
        chk("after_noise", 80'({rc, ro, rs}), 80'({ec, eo, es}));

        // Asynchronous reset after the second RUN edge
        x = 64'hAAAA_BBBB_CCCC_DDDD; y = 64'h1234_5678_9ABC_DEF0; op = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_run_reset", 80'({in_ready, out_valid, cout, ovf, s}), 80'({1'b1, 1'b0, 1'b0, 1'b0, 64'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(64'd1, 64'd2, 1'b0, 1'b1, 0, 1'b0, rs, rc, ro, lat);
        chk("post_reset_op", 80'({rc, ro, rs}), 80'({1'b0, 1'b0, 64'd4}));

        // Randomized operations with random output stalls
        for (int n = 0; n < 1024; n++) begin
            rx = {$urandom, $urandom};
            ry = (n % 16 == 0) ? rx : {$urandom, $urandom};
            rop = 1'($urandom);
            rcin = 1'($urandom);
            model(rx, ry, rop, rcin, es, ec, eo);
            do_op(rx, ry, rop, rcin, int'($urandom_range(0, 3)), 1'b0, rs, rc, ro, lat);
            chk("random", 80'({rc, ro, rs}), 80'({ec, eo, es}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
